// File: rtl/trng_pkg.sv
// ----------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the TRNG capture path: sequencer state encoding and
// the byte width used on every data port.
// ----------------------------------------------------------------------------
package trng_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_GUARD = 2'd1,
        ST_FILL  = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

endpackage

// File: rtl/trng_rct.sv
// ----------------------------------------------------------------------------
// trng_rct
// Repetition-count health test on the bytes written into the capture FIFO.
// Only built when TRNG_CAPTURE_CTRL_RCT_EN is defined.
//
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   en             : a byte is being written this cycle
//   dat            : the byte being written
//   trip           : combinational; this byte makes RCT_LIMIT identical
//                    consecutive bytes
// ----------------------------------------------------------------------------
`ifdef TRNG_CAPTURE_CTRL_RCT_EN
module trng_rct
    import trng_pkg::*;
#(
    parameter int unsigned RCT_LIMIT = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              en,
    input  logic [BYTE_W-1:0] dat,
    output logic              trip
);

    localparam int unsigned CW = $clog2(RCT_LIMIT + 1);

    logic [CW-1:0]     run_len;
    logic [CW-1:0]     run_next;
    logic [BYTE_W-1:0] last;

    // run_len == 0 means no previous byte, so the first byte starts a run of 1
    always_comb begin
        run_next = CW'(1);
        if (run_len != '0 && dat == last) begin
            run_next = run_len + CW'(1);
        end
    end

    assign trip = en && (run_next == CW'(RCT_LIMIT));

    // The run restarts after a trip so the alarm is raised once per run
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_len <= '0;
            last    <= '0;
        end else if (en) begin
            last    <= dat;
            run_len <= trip ? '0 : run_next;
        end
    end

endmodule
`endif

// File: rtl/trng_capture_ctrl.sv
// ----------------------------------------------------------------------------
// trng_capture_ctrl
// Sequencer for the TRNG capture path: pulses the TRNG reset, discards a guard
// window of output, fills the FIFO at full TRNG rate, then drains it one byte
// per serial-link handshake. Re-seeds every RESET_EVERY complete dumps.
//
// Optional feature macro: TRNG_CAPTURE_CTRL_RCT_EN (repetition-count alarm).
//
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   o_trng_reset            : TRNG reset (combinational)
//   i_trng_valid/i_trng_dat : TRNG byte stream
//   o_trng_read             : TRNG byte consume (combinational)
//   o_fifo_write/o_fifo_dat : FIFO write port
//   i_fifo_full             : FIFO full
//   i_fifo_almost_empty     : exactly one entry left in the FIFO
//   o_fifo_read/i_fifo_dat  : FIFO read port, data valid one cycle after read
//   i_com_ready             : serial link can accept a byte
//   o_com_write/o_com_dat   : one-cycle byte strobe to the serial link
//   o_state                 : RST=0, GUARD=1, FILL=2, DUMP=3
//   o_dump_cnt              : completed dumps, wraps
//   o_alarm                 : sticky health alarm (0 without the macro)
// ----------------------------------------------------------------------------
module trng_capture_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned GUARD_CYCLES = 512,
    parameter int unsigned RESET_EVERY  = 1,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned RCT_LIMIT    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic                 o_trng_reset,
    input  logic                 i_trng_valid,
    input  logic [BYTE_W-1:0]    i_trng_dat,
    output logic                 o_trng_read,
    output logic                 o_fifo_write,
    output logic [BYTE_W-1:0]    o_fifo_dat,
    input  logic                 i_fifo_full,
    input  logic                 i_fifo_almost_empty,
    output logic                 o_fifo_read,
    input  logic [BYTE_W-1:0]    i_fifo_dat,
    input  logic                 i_com_ready,
    output logic                 o_com_write,
    output logic [BYTE_W-1:0]    o_com_dat,
    output logic [1:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_dump_cnt,
    output logic                 o_alarm
);

    state_t state;
    state_t state_next;

    logic [CNT_WIDTH-1:0] phase_cnt;   // dwell counter for RST and GUARD
    logic [CNT_WIDTH-1:0] since_rst;   // completed dumps since the last TRNG reset
    logic                 rd_wait;     // read issued last cycle, FIFO data valid now
    logic                 last_xfer;   // in-flight transfer carries the final entry

    logic xfer_busy;
    logic issue_rd;
    logic dump_done;
    logic fill_byte;
    logic rst_done;
    logic guard_done;
    logic reseed;
    logic rct_trip;

    assign xfer_busy  = o_fifo_read | rd_wait | o_com_write;
    assign issue_rd   = (state == ST_DUMP) && i_com_ready && !xfer_busy;
    assign dump_done  = (state == ST_DUMP) && o_com_write && last_xfer;
    // A byte that arrives while full is visible is consumed but never written
    assign fill_byte  = (state == ST_FILL) && i_trng_valid && !i_fifo_full;
    assign rst_done   = phase_cnt == CNT_WIDTH'(RESET_CYCLES - 1);
    assign guard_done = phase_cnt == CNT_WIDTH'(GUARD_CYCLES - 1);
    assign reseed     = since_rst == CNT_WIDTH'(RESET_EVERY - 1);

    assign o_trng_reset = i_reset || (state == ST_RST);
    assign o_trng_read  = ((state == ST_GUARD) || (state == ST_FILL)) && i_trng_valid;
    assign o_state      = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_RST: begin
                if (rst_done) state_next = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard_done) state_next = ST_FILL;
            end
            ST_FILL: begin
                if (rct_trip) begin
                    state_next = ST_RST;
                end else if (i_fifo_full) begin
                    state_next = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (dump_done) state_next = reseed ? ST_RST : ST_FILL;
            end
            default: state_next = ST_RST;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, FIFO write path and the DUMP read/forward handshake
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_cnt    <= '0;
            since_rst    <= '0;
            o_dump_cnt   <= '0;
            o_fifo_write <= 1'b0;
            o_fifo_dat   <= '0;
            o_fifo_read  <= 1'b0;
            rd_wait      <= 1'b0;
            last_xfer    <= 1'b0;
            o_com_write  <= 1'b0;
            o_com_dat    <= '0;
        end else begin
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if ((state == ST_RST) || (state == ST_GUARD)) begin
                phase_cnt <= phase_cnt + CNT_WIDTH'(1);
            end

            o_fifo_write <= fill_byte;
            if (fill_byte) begin
                o_fifo_dat <= i_trng_dat;
            end

            o_fifo_read <= issue_rd;
            if (issue_rd) begin
                last_xfer <= i_fifo_almost_empty;
            end
            rd_wait     <= o_fifo_read;
            o_com_write <= rd_wait;
            if (rd_wait) begin
                o_com_dat <= i_fifo_dat;
            end

            if (dump_done) begin
                o_dump_cnt <= o_dump_cnt + CNT_WIDTH'(1);
            end
            // Any entry into RST (re-seed or alarm) restarts the dump schedule
            if ((state_next == ST_RST) && (state != ST_RST)) begin
                since_rst <= '0;
            end else if (dump_done) begin
                since_rst <= since_rst + CNT_WIDTH'(1);
            end
        end
    end

`ifdef TRNG_CAPTURE_CTRL_RCT_EN
    // The tripping byte is still written; the fill is abandoned after it
    trng_rct #(
        .RCT_LIMIT (RCT_LIMIT)
    ) u_rct (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .en      (fill_byte),
        .dat     (i_trng_dat),
        .trip    (rct_trip)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alarm <= 1'b0;
        end else if (rct_trip) begin
            o_alarm <= 1'b1;
        end
    end
`else
    // RCT_LIMIT has no effect without the health test
    logic unused_rct_limit;
    assign unused_rct_limit = ^RCT_LIMIT;
    assign rct_trip         = 1'b0;
    assign o_alarm          = 1'b0;
`endif

endmodule

// File: doc/trng_capture_ctrl.md
# trng_capture_ctrl

Sequencer for the TRNG capture path. It replaces the ad-hoc glue around `sb_trng`, `fifo` and `trng_com` with one explicit state machine. Each round it pulses the TRNG reset, discards output for a guard window, fills the FIFO at full TRNG rate, then drains it one byte per serial-link handshake. A periodic re-seed is scheduled every `RESET_EVERY` dumps.

## Interface
Parameters:
- `RESET_CYCLES`, 2: cycles `o_trng_reset` is held in state RST (≥1).
- `GUARD_CYCLES`, 512: cycles of discarded TRNG output after each reset (≥1).
- `RESET_EVERY`, 1: number of complete FIFO dumps between TRNG resets (≥1).
- `CNT_WIDTH`, 16: width of the guard and dump counters.
- `RCT_LIMIT`, 32: repetition-count alarm threshold. Only used with `TRNG_CAPTURE_CTRL_RCT_EN`.

Ports:
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `o_trng_reset` out 1: TRNG reset.
- `i_trng_valid` in 1: TRNG byte ready.
- `i_trng_dat` in 8: TRNG byte.
- `o_trng_read` out 1: TRNG byte consume.
- `o_fifo_write` out 1: FIFO write strobe.
- `o_fifo_dat` out 8: FIFO write data.
- `i_fifo_full` in 1: FIFO full.
- `i_fifo_almost_empty` in 1: exactly one entry left in FIFO.
- `o_fifo_read` out 1: FIFO read strobe.
- `i_fifo_dat` in 8: FIFO read data, registered, valid the cycle after `o_fifo_read`.
- `i_com_ready` in 1: serial link can accept a byte.
- `o_com_write` out 1: one-cycle byte strobe to the serial link.
- `o_com_dat` out 8: byte to the serial link.
- `o_state` out 2: current state (RST=0, GUARD=1, FILL=2, DUMP=3).
- `o_dump_cnt` out `CNT_WIDTH`: completed dumps, wraps.
- `o_alarm` out 1: sticky health alarm. Tied 0 without the macro.

## Operation
- Reset (`i_reset`): state RST, all counters 0, `o_fifo_write`/`o_fifo_read`/`o_com_write`/`o_alarm` = 0, data outputs 0, `o_dump_cnt` = 0. `o_trng_reset` = `i_reset` | (state==RST), combinational.
- RST: hold for `RESET_CYCLES`, then go to GUARD with the guard counter at 0.
- GUARD: `o_trng_read` = `i_trng_valid`; bytes are discarded. After `GUARD_CYCLES` cycles, go to FILL.
- FILL: `o_trng_read` = `i_trng_valid`. Each valid byte is registered into `o_fifo_dat` with `o_fifo_write` = 1 on the next cycle. When `i_fifo_full` is seen, go to DUMP. A byte arriving in the same cycle `i_fifo_full` is seen is consumed and dropped, never written.
- DUMP: `o_trng_read` = 0; the TRNG keeps running. Sub-sequence, at most one transfer outstanding:
  - Pulse `o_fifo_read` when `i_com_ready` is high and nothing is outstanding.
  - Capture `i_fifo_dat` one cycle later.
  - Pulse `o_com_write` with `o_com_dat` in the following cycle.
  - No new read is issued until `o_com_write` has deasserted and `i_com_ready` is high again.
- End of dump: if `i_fifo_almost_empty` was high when the read was issued, then after its `o_com_write`, `o_dump_cnt` increments. If the number of dumps since the last reset equals `RESET_EVERY`, go to RST; otherwise go to FILL. No guard window applies in the FILL-only case.
- `i_reset` mid-operation aborts any outstanding transfer and drops the captured byte. The surrounding FIFO is reset by the same signal.

## Timing
- TRNG byte to FIFO write: 1 cycle latency.
- `o_fifo_read` to `o_com_write`: 2 cycles. Throughput is limited to one byte per `i_com_ready` cycle.
- After `i_reset` deasserts, the first FILL cycle is cycle `RESET_CYCLES` + `GUARD_CYCLES`.
- All outputs are registered except `o_trng_reset` and `o_trng_read`.

## Configuration
- `TRNG_CAPTURE_CTRL_RCT_EN` defined: a repetition-count test runs on every byte written in FILL.
  - Identical consecutive bytes increment a counter; a differing byte resets it to 1.
  - When the counter reaches `RCT_LIMIT`: `o_alarm` is set (sticky until `i_reset`), the FIFO fill is aborted, and the block goes to RST. Its effect on `o_dump_cnt` is that no increment occurs.
- Undefined: no counter is built, `o_alarm` = 0, `RCT_LIMIT` is ignored.

## Structure
- Shared package `trng_pkg`: state enum/localparams (RST, GUARD, FILL, DUMP) and the byte width constant 8.
- Optional sub-module `trng_rct`: the repetition-count checker, instantiated only under the macro.
- Counters and the DUMP handshake stay in the top FSM.

## Test plan
- Bench parameters for all scenarios: `GUARD_CYCLES`=8, 4-entry FIFO.
- Reset release -> `o_trng_reset` high for exactly 2 cycles, `o_state` = 1 for 8 cycles, no `o_fifo_write` during the guard window.
- TRNG bytes 0x11, 0x22, 0x33, 0x44, one per 3 cycles -> 4 `o_fifo_write` pulses, each 1 cycle after its valid, then `o_state` = 3.
- `i_com_ready` toggled 1 cycle high every 20 cycles -> exactly 4 `o_com_write` pulses, bytes 0x11..0x44 in order, each 2 cycles after `o_fifo_read`.
- `RESET_EVERY`=2 -> after the first dump `o_dump_cnt` = 1 and the state goes straight to FILL; after the second dump `o_dump_cnt` = 2 and `o_trng_reset` pulses.
- `i_reset` asserted between `o_fifo_read` and `o_com_write` -> no `o_com_write`, `o_state` = 0, all strobes 0 on the next cycle.
- With `TRNG_CAPTURE_CTRL_RCT_EN` and `RCT_LIMIT`=3, feed 0xAA ×3 -> `o_alarm` = 1, state RST, `o_dump_cnt` unchanged.
